// File: rtl/seq_divider.sv
// Sequential restoring divider: recomputes quotient/remainder one bit per clock whenever the operands change.
// Optional feature macro: SEQ_DIVIDER_EARLY_EXIT_EN (divisor > dividend completes at the start edge).
module seq_divider #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             busy,
   output logic             done,
   output logic             div_by_zero
);

   localparam int CW = $clog2(WIDTH);

   typedef enum logic {IDLE, CALC} state_t;

   state_t           state_q;
   logic [WIDTH-1:0] op_a_q;
   logic [WIDTH-1:0] op_b_q;
   logic             pending_q;
   logic [WIDTH-1:0] rem_q;
   logic [WIDTH-1:0] qsr_q;
   logic [CW-1:0]    cnt_q;
   logic [WIDTH-1:0] quotient_q;
   logic [WIDTH-1:0] remainder_q;
   logic             busy_q;
   logic             done_q;
   logic             dbz_q;

   logic             changed;
   logic             last_iter;
   logic             launch;
   logic             early_exit;
   logic [WIDTH:0]   shifted;
   logic             fits;
   logic [WIDTH-1:0] rem_d;
   logic [WIDTH-1:0] qsr_d;

   assign changed   = {dividend, divisor} != {op_a_q, op_b_q};
   assign last_iter = (cnt_q == CW'(WIDTH - 1));

   // The completion edge always wins; an operand change there is picked up from IDLE one edge later.
   assign launch = ((state_q == IDLE) && (pending_q || changed)) ||
                   ((state_q == CALC) && !last_iter && changed);

`ifdef SEQ_DIVIDER_EARLY_EXIT_EN
   assign early_exit = (divisor > dividend);
`else
   assign early_exit = 1'b0;
`endif

   // One restoring step: the shifted partial remainder carries an extra bit so the compare is exact.
   always_comb begin
      shifted = {rem_q, qsr_q[WIDTH-1]};
      fits    = (shifted >= {1'b0, op_b_q});
      rem_d   = fits ? WIDTH'(shifted - {1'b0, op_b_q}) : shifted[WIDTH-1:0];
      qsr_d   = {qsr_q[WIDTH-2:0], fits};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         op_a_q      <= '0;
         op_b_q      <= '0;
         pending_q   <= 1'b1;
         rem_q       <= '0;
         qsr_q       <= '0;
         cnt_q       <= '0;
         quotient_q  <= '0;
         remainder_q <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         dbz_q       <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (launch) begin
            op_a_q    <= dividend;
            op_b_q    <= divisor;
            pending_q <= 1'b0;
            if (divisor == '0) begin
               state_q     <= IDLE;
               busy_q      <= 1'b0;
               quotient_q  <= '1;
               remainder_q <= dividend;
               dbz_q       <= 1'b1;
               done_q      <= 1'b1;
            end else if (early_exit) begin
               state_q     <= IDLE;
               busy_q      <= 1'b0;
               quotient_q  <= '0;
               remainder_q <= dividend;
               dbz_q       <= 1'b0;
               done_q      <= 1'b1;
            end else begin
               state_q <= CALC;
               busy_q  <= 1'b1;
               rem_q   <= '0;
               qsr_q   <= dividend;
               cnt_q   <= '0;
            end
         end else if (state_q == CALC) begin
            rem_q <= rem_d;
            qsr_q <= qsr_d;
            cnt_q <= cnt_q + CW'(1);
            if (last_iter) begin
               state_q     <= IDLE;
               busy_q      <= 1'b0;
               done_q      <= 1'b1;
               quotient_q  <= qsr_d;
               remainder_q <= rem_d;
               dbz_q       <= 1'b0;
            end
         end
      end
   end

   assign quotient    = quotient_q;
   assign remainder   = remainder_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: the driver queues expected results and completion edges,
// a monitor pops one entry per done pulse and tracks the expected busy window.
module tb_seq_divider;

   localparam int W = 4;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic [W-1:0] dividend = '0;
   logic [W-1:0] divisor = '0;
   logic [W-1:0] quotient;
   logic [W-1:0] remainder;
   logic         busy;
   logic         done;
   logic         div_by_zero;

   seq_divider #(.WIDTH(W)) dut (
      .clk        (clk),
      .reset      (reset),
      .dividend   (dividend),
      .divisor    (divisor),
      .quotient   (quotient),
      .remainder  (remainder),
      .busy       (busy),
      .done       (done),
      .div_by_zero(div_by_zero)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] q;
      logic [W-1:0] r;
      logic         dbz;
      int           edge_no;
   } exp_t;

   exp_t         sb[$];
   int           total = 0;
   int           bad = 0;
   int           edge_cnt = 0;
   int           calc_start = 0;
   int           calc_end = 0;
   bit           mon_en = 1'b0;
   bit           pending_m = 1'b1;
   logic [W-1:0] cap_a = '0;
   logic [W-1:0] cap_b = '0;
   logic [W-1:0] last_q = '0;
   logic [W-1:0] last_r = '0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, req, edge_cnt);
      end
   endtask

   // Expected behaviour per operand change: result from plain arithmetic, completion edge from the latency rules.
   task automatic apply(input int a, input int b);
      int   e;
      int   st;
      int   lat;
      bit   abort;
      exp_t x;
      e        = edge_cnt + 1;
      dividend = W'(a);
      divisor  = W'(b);
      if (!pending_m && W'(a) == cap_a && W'(b) == cap_b) return;
      st    = (calc_end == e && calc_start < calc_end) ? e + 1 : e;
      abort = (calc_end > e);
      if (abort && sb.size() > 0) void'(sb.pop_back());
      if (b == 0) begin
         x.q   = '1;
         x.r   = W'(a);
         x.dbz = 1'b1;
         lat   = 0;
      end else begin
         x.q   = W'(a / b);
         x.r   = W'(a % b);
         x.dbz = 1'b0;
         lat   = W;
`ifdef SEQ_DIVIDER_EARLY_EXIT_EN
         if (b > a) lat = 0;
`endif
      end
      x.edge_no = st + lat;
      sb.push_back(x);
      calc_start = abort ? calc_start : st;
      calc_end   = st + lat;
      pending_m  = 1'b0;
      cap_a      = W'(a);
      cap_b      = W'(b);
      $display("issue %0d/%0d start_edge=%0d expect q=%0d r=%0d dbz=%0d at edge %0d",
               a, b, st, x.q, x.r, x.dbz, x.edge_no);
   endtask

   task automatic do_reset(input int a, input int b, input int n);
      reset      = 1'b1;
      dividend   = W'(a);
      divisor    = W'(b);
      sb.delete();
      calc_start = 0;
      calc_end   = 0;
      last_q     = '0;
      last_r     = '0;
      repeat (n) @(negedge clk);
      mon_en = 1'b1;
      check("rst_quotient", quotient, 0);
      check("rst_remainder", remainder, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_dbz", div_by_zero, 0);
      reset     = 1'b0;
      pending_m = 1'b1;
      apply(a, b);
   endtask

   task automatic check_out(input string name, input int q, input int r);
      check({name, "_q"}, quotient, q);
      check({name, "_r"}, remainder, r);
   endtask

   // Monitor: one sample per cycle, just after the active edge.
   initial begin
      exp_t x;
      logic exp_busy;
      forever begin
         @(posedge clk);
         #1;
         edge_cnt++;
         if (mon_en) begin
            exp_busy = (edge_cnt >= calc_start && edge_cnt < calc_end);
            check("busy", busy, exp_busy);
            check("busy_and_done", busy && done, 0);
            if (done === 1'b1) begin
               if (sb.size() == 0) begin
                  check("done_unexpected", done, 0);
               end else begin
                  x = sb.pop_front();
                  check("done_edge", edge_cnt, x.edge_no);
                  check("quotient", quotient, x.q);
                  check("remainder", remainder, x.r);
                  check("div_by_zero", div_by_zero, x.dbz);
                  last_q = x.q;
                  last_r = x.r;
                  $display("done edge=%0d q=%0d r=%0d dbz=%0d", edge_cnt, quotient, remainder, div_by_zero);
               end
            end
         end
      end
   end

   initial begin
      int a;
      int b;
      @(negedge clk);
      // 9/2 after reset, busy for exactly W cycles
      do_reset(9, 2, 2);
      repeat (7) @(negedge clk);
      check_out("t1", 4, 1);
      // divide by zero completes on the start edge
      apply(7, 0);
      repeat (3) @(negedge clk);
      check_out("t2", 15, 7);
      check("t2_dbz", div_by_zero, 1);
      // abort 8/3 two cycles in, restart with 6/3
      apply(8, 3);
      repeat (2) @(negedge clk);
      apply(6, 3);
      repeat (7) @(negedge clk);
      check_out("t3", 2, 0);
      // reset during iteration 2 of 15/1
      apply(15, 1);
      repeat (3) @(negedge clk);
      do_reset(15, 1, 1);
      repeat (7) @(negedge clk);
      check_out("t4", 15, 0);
      // divisor larger than dividend
      apply(3, 9);
      repeat (7) @(negedge clk);
      check_out("t5", 0, 3);
      // hold operands: no further activity
      apply(9, 2);
      repeat (26) @(negedge clk);
      check_out("t6", 4, 1);
      check("t6_queue", sb.size(), 0);
      // random operand changes, including aborts and completion-edge collisions
      repeat (40) begin
         a = int'($urandom_range(0, 15));
         b = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 15));
         apply(a, b);
         repeat ($urandom_range(2, 7)) @(negedge clk);
      end
      repeat (10) @(negedge clk);
      check("final_queue", sb.size(), 0);
      check_out("final", int'(last_q), int'(last_r));
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
